// File: rtl/downsamp_pkg.sv
// Shared types and helpers for the decimating accumulator.
package downsamp_pkg;

    // Output word selection.
    typedef enum logic [1:0] {
        MODE_SUM  = 2'd0,
        MODE_AVG  = 2'd1,
        MODE_PICK = 2'd2
    } mode_e;

    // Working width of the sample conversion helper; callers cast the result down.
    localparam int CONV_W = 64;

    // Output width: enough headroom for 2^max_log2 full-scale samples.
    function automatic int out_width(input int data_w, input int max_log2);
        return data_w + max_log2;
    endfunction

    // Offset binary: invert the MSB and zero-extend. Otherwise sign-extend.
    function automatic logic [CONV_W-1:0] conv_sample(input logic [CONV_W-1:0] x,
                                                      input int data_w,
                                                      input logic offset_bin);
        logic [CONV_W-1:0] r;
        logic              msb;
        r   = '0;
        msb = 1'b0;
        for (int i = 0; i < CONV_W; i++) begin
            if (i == data_w - 1) msb = x[i];
        end
        for (int i = 0; i < CONV_W; i++) begin
            if (i < data_w - 1)       r[i] = x[i];
            else if (i == data_w - 1) r[i] = offset_bin ? ~msb : msb;
            else                      r[i] = offset_bin ? 1'b0 : msb;
        end
        return r;
    endfunction

endpackage

// File: rtl/downsamp_ch.sv
// One channel: running accumulator, first-sample store and result formatter.
// The result is combinational and valid on the frame's completing sample.
module downsamp_ch
    import downsamp_pkg::*;
#(
    parameter  int DATA_WIDTH     = 14,
    parameter  int MAX_LOG2_RATIO = 4,
    parameter  int RW             = 3,
    localparam int OW             = out_width(DATA_WIDTH, MAX_LOG2_RATIO)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic                  i_first,
    input  logic [DATA_WIDTH-1:0] i_sample,
    input  logic                  i_offset_bin,
    input  logic [1:0]            i_mode,
    input  logic [RW-1:0]         i_log2_ratio,
    output logic [OW-1:0]         o_result
);

    // Divide by 2^r: logical for offset binary, arithmetic for two's complement.
    function automatic logic signed [OW-1:0] avg_shift(input logic signed [OW-1:0] v,
                                                       input logic [RW-1:0]        r,
                                                       input logic                 uns);
        if (uns) return v >> r;
        else     return v >>> r;
    endfunction

    logic signed [OW-1:0] w_x;
    logic signed [OW-1:0] w_sum;
    logic signed [OW-1:0] w_pick;
    logic signed [OW-1:0] r_acc_p0;
    logic signed [OW-1:0] r_pick_p0;

    // Stage p0: converted sample folded into the running frame sum.
    assign w_x    = OW'(conv_sample(CONV_W'(i_sample), DATA_WIDTH, i_offset_bin));
    assign w_sum  = i_first ? w_x : r_acc_p0 + w_x;
    assign w_pick = i_first ? w_x : r_pick_p0;

    // Accumulate every valid sample; remember the first one of each frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_p0  <= '0;
            r_pick_p0 <= '0;
        end else if (i_valid) begin
            r_acc_p0 <= w_sum;
            if (i_first) r_pick_p0 <= w_x;
        end
    end

    // Format the frame result; the reserved mode falls through to sum.
    always_comb begin
        o_result = w_sum;
        if (i_mode == MODE_AVG)       o_result = avg_shift(w_sum, i_log2_ratio, i_offset_bin);
        else if (i_mode == MODE_PICK) o_result = w_pick;
    end

endmodule

// File: rtl/downsamp_acc.sv
// Multi-channel decimating accumulator with valid/ready output and drop counter.
module downsamp_acc
    import downsamp_pkg::*;
#(
    parameter  int DATA_WIDTH     = 14,
    parameter  int MAX_LOG2_RATIO = 4,
    parameter  int NUM_CH         = 2,
    parameter  int CNT_WIDTH      = 16,
    localparam int OW             = out_width(DATA_WIDTH, MAX_LOG2_RATIO),
    localparam int RW             = $clog2(MAX_LOG2_RATIO + 1),
    localparam int CW             = MAX_LOG2_RATIO
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [RW-1:0]                cfg_log2_ratio,
    input  logic [1:0]                   cfg_mode,
    input  logic                         cfg_offset_bin,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH*OW-1:0]         out_data,
    output logic [CNT_WIDTH-1:0]         overflow_cnt,
    output logic                         frame_active
);

    // Saturating increment for the drop counter.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic [CW-1:0]        r_cnt;
    logic [RW-1:0]        r_cfg_r;
    logic [1:0]           r_cfg_mode;
    logic                 r_cfg_ob;
    logic                 r_active;
    logic                 r_vld_p1;
    logic [NUM_CH*OW-1:0] r_out_data_p1;
    logic [CNT_WIDTH-1:0] r_ovf_cnt;

    logic                 w_first;
    logic [RW-1:0]        w_r_clamped;
    logic [RW-1:0]        w_r;
    logic [1:0]           w_mode;
    logic                 w_ob;
    logic [CW-1:0]        w_last_idx;
    logic                 w_last;
    logic [NUM_CH*OW-1:0] w_res;

    // The first sample of a frame uses the live config; the rest use the latched copy.
    assign w_first     = (r_cnt == '0);
    assign w_r_clamped = (cfg_log2_ratio > RW'(MAX_LOG2_RATIO)) ? RW'(MAX_LOG2_RATIO) : cfg_log2_ratio;
    assign w_r         = w_first ? w_r_clamped    : r_cfg_r;
    assign w_mode      = w_first ? cfg_mode       : r_cfg_mode;
    assign w_ob        = w_first ? cfg_offset_bin : r_cfg_ob;
    assign w_last_idx  = ~({CW{1'b1}} << w_r);
    assign w_last      = in_valid && (r_cnt == w_last_idx);

    // Stage p0: per-channel accumulation.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        downsamp_ch #(
            .DATA_WIDTH    (DATA_WIDTH),
            .MAX_LOG2_RATIO(MAX_LOG2_RATIO),
            .RW            (RW)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .i_valid     (in_valid),
            .i_first     (w_first),
            .i_sample    (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .i_offset_bin(w_ob),
            .i_mode      (w_mode),
            .i_log2_ratio(w_r),
            .o_result    (w_res[g*OW +: OW])
        );
    end

    // Sample counter wraps on the completing sample of each frame.
    always_ff @(posedge clk) begin
        if (rst)           r_cnt <= '0;
        else if (in_valid) r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end

    // Latch the configuration on the sample that opens a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_r    <= '0;
            r_cfg_mode <= '0;
            r_cfg_ob   <= 1'b0;
        end else if (in_valid && w_first) begin
            r_cfg_r    <= w_r_clamped;
            r_cfg_mode <= cfg_mode;
            r_cfg_ob   <= cfg_offset_bin;
        end
    end

    // Frame is in progress between its first and completing samples.
    always_ff @(posedge clk) begin
        if (rst)           r_active <= 1'b0;
        else if (in_valid) r_active <= !w_last;
    end

    // Stage p1: result register with handshake; completions that find it full are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1      <= 1'b0;
            r_out_data_p1 <= '0;
            r_ovf_cnt     <= '0;
        end else if (w_last) begin
            if (!r_vld_p1 || out_ready) begin
                r_vld_p1      <= 1'b1;
                r_out_data_p1 <= w_res;
            end else begin
                r_ovf_cnt <= sat_inc(r_ovf_cnt);
            end
        end else if (r_vld_p1 && out_ready) begin
            r_vld_p1 <= 1'b0;
        end
    end

    assign out_valid    = r_vld_p1;
    assign out_data     = r_out_data_p1;
    assign overflow_cnt = r_ovf_cnt;
    assign frame_active = r_active;

endmodule

// File: tb/tb_downsamp_acc.sv
// Self-checking bench for downsamp_acc: directed scenarios plus randomized traffic
// against a frame-level reference model.
module tb_downsamp_acc;

    localparam int DW  = 14;
    localparam int MLR = 4;
    localparam int NCH = 2;
    localparam int CNW = 16;
    localparam int OW  = DW + MLR;
    localparam int RW  = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic [NCH*DW-1:0]  in_data;
    logic [RW-1:0]      cfg_log2_ratio;
    logic [1:0]         cfg_mode;
    logic               cfg_offset_bin;
    logic               out_valid;
    logic               out_ready;
    logic [NCH*OW-1:0]  out_data;
    logic [CNW-1:0]     overflow_cnt;
    logic               frame_active;

    downsamp_acc #(
        .DATA_WIDTH    (DW),
        .MAX_LOG2_RATIO(MLR),
        .NUM_CH        (NCH),
        .CNT_WIDTH     (CNW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .cfg_log2_ratio(cfg_log2_ratio),
        .cfg_mode      (cfg_mode),
        .cfg_offset_bin(cfg_offset_bin),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .overflow_cnt  (overflow_cnt),
        .frame_active  (frame_active)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: frame sample lists and the visible output state.
    int q [NCH][$];
    int m_r;
    int m_mode;
    bit m_ob;
    bit m_valid;
    int m_data [NCH];
    int m_ovf;

    function automatic int conv(input int raw, input bit ob);
        if (ob) return raw ^ (1 << (DW-1));
        return (raw >= (1 << (DW-1))) ? raw - (1 << DW) : raw;
    endfunction

    function automatic int floor_div(input int s, input int d);
        if (s >= 0) return s / d;
        return -((-s + d - 1) / d);
    endfunction

    task automatic model_update();
        bit done;
        int res [NCH];
        int sum;
        done = 1'b0;
        if (rst) begin
            for (int ch = 0; ch < NCH; ch++) begin
                q[ch].delete();
                m_data[ch] = 0;
            end
            m_valid = 1'b0;
            m_ovf   = 0;
            return;
        end
        if (in_valid) begin
            if (q[0].size() == 0) begin
                m_r    = (int'(cfg_log2_ratio) > MLR) ? MLR : int'(cfg_log2_ratio);
                m_mode = int'(cfg_mode);
                m_ob   = cfg_offset_bin;
            end
            for (int ch = 0; ch < NCH; ch++)
                q[ch].push_back(conv(int'(in_data[ch*DW +: DW]), m_ob));
            if (q[0].size() == (1 << m_r)) begin
                done = 1'b1;
                for (int ch = 0; ch < NCH; ch++) begin
                    sum = 0;
                    foreach (q[ch][k]) sum += q[ch][k];
                    case (m_mode)
                        1:       res[ch] = floor_div(sum, 1 << m_r);
                        2:       res[ch] = q[ch][0];
                        default: res[ch] = sum;
                    endcase
                    q[ch].delete();
                end
            end
        end
        if (done) begin
            if (!m_valid || out_ready) begin
                m_valid = 1'b1;
                for (int ch = 0; ch < NCH; ch++) m_data[ch] = res[ch];
            end else if (m_ovf < (1 << CNW) - 1) begin
                m_ovf++;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_outputs();
        logic [NCH*OW-1:0] e;
        for (int ch = 0; ch < NCH; ch++) e[ch*OW +: OW] = OW'(m_data[ch]);
        check("out_valid",    64'(out_valid),    64'(m_valid));
        check("out_data",     64'(out_data),     64'(e));
        check("overflow_cnt", 64'(overflow_cnt), 64'(m_ovf));
        check("frame_active", 64'(frame_active), 64'(q[0].size() != 0));
    endtask

    // Drive one cycle, check at the falling edge, advance model with the same inputs.
    task automatic step(input bit v, input logic [NCH*DW-1:0] d, input bit rdy);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        @(negedge clk);
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NCH*DW-1:0] pk(input int a, input int b);
        return {DW'(b), DW'(a)};
    endfunction

    task automatic set_cfg(input int r, input int mode, input bit ob);
        cfg_log2_ratio = RW'(r);
        cfg_mode       = 2'(mode);
        cfg_offset_bin = ob;
    endtask

    initial begin
        int sv [4];
        sv = '{100, -50, 7, -1};
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        set_cfg(0, 0, 1'b0);
        @(posedge clk);
        #1;
        step(1'b0, '0, 1'b0);
        step(1'b1, pk(3, 4), 1'b1);
        rst = 1'b0;

        // Signed sum over four samples.
        set_cfg(2, 0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, pk(sv[i], $urandom_range(0, 16383)), 1'b1);
        check("sum_vld", 64'(out_valid), 64'(1));
        check("sum56", 64'(out_data[OW-1:0]), 64'(18'd56));
        step(1'b0, '0, 1'b1);

        // Offset-binary average at the extremes.
        set_cfg(4, 1, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, pk(14'h2000, 14'h2000), 1'b1);
        check("avg_min", 64'(out_data[OW-1:0]), 64'(0));
        for (int i = 0; i < 16; i++) step(1'b1, pk(14'h1FFF, 14'h1FFF), 1'b1);
        check("avg_max", 64'(out_data[OW-1:0]), 64'(18'h3FFF));

        // Pick mode with a mid-frame ratio change.
        set_cfg(3, 2, 1'b0);
        step(1'b1, pk(5, 1), 1'b1);
        step(1'b1, pk(9, 1), 1'b1);
        set_cfg(1, 2, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, pk(9, 1), 1'b1);
        check("pick5", 64'(out_data[OW-1:0]), 64'(5));
        step(1'b1, pk(7, 2), 1'b1);
        step(1'b1, pk(3, 2), 1'b1);
        check("pick_r1_vld", 64'(out_valid), 64'(1));
        check("pick7", 64'(out_data[OW-1:0]), 64'(7));
        step(1'b0, '0, 1'b1);

        // Back-pressure drops with R=0.
        set_cfg(0, 0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, pk(11 + i, 0), 1'b0);
        check("bp_hold", 64'(out_data[OW-1:0]), 64'(11));
        check("bp_ovf", 64'(overflow_cnt), 64'(4));
        step(1'b0, '0, 1'b1);
        check("bp_drain", 64'(out_valid), 64'(0));
        check("bp_ovf_hold", 64'(overflow_cnt), 64'(4));

        // Continuous R=0 stream with the consumer always ready.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, NCH*DW'($urandom), 1'b1);
            check("stream_vld", 64'(out_valid), 64'(1));
        end
        step(1'b0, '0, 1'b1);

        // Reset in the middle of a frame.
        set_cfg(2, 0, 1'b0);
        step(1'b1, pk(50, 50), 1'b1);
        step(1'b1, pk(60, 60), 1'b1);
        rst = 1'b1;
        step(1'b0, '0, 1'b1);
        rst = 1'b0;
        check("rst_active", 64'(frame_active), 64'(0));
        check("rst_ovf", 64'(overflow_cnt), 64'(0));
        for (int i = 0; i < 4; i++) step(1'b1, pk(1, 1), 1'b1);
        check("rst_sum4", 64'(out_data[OW-1:0]), 64'(4));
        step(1'b0, '0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            set_cfg($urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            step($urandom_range(0, 9) < 7, NCH*DW'($urandom), $urandom_range(0, 9) < 6);
        end
        rst = 1'b0;
        step(1'b0, '0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/downsamp_acc.md
Name: downsamp_acc

Overview:
Multi-channel decimating accumulator for the ADC capture path. It collects 2^R input samples per channel (R selectable at run time) and produces one output word per channel per frame. The output word is the frame sum, the frame average, or the first sample of the frame (pick mode). It sits between the ADC sample interface and the packetiser/DMA stage. A valid/ready output handshake applies back-pressure, and an overflow counter records every result lost to that back-pressure.

Parameters:
DATA_WIDTH, 14, width of one input sample per channel
MAX_LOG2_RATIO, 4, largest supported decimation exponent; output width is DATA_WIDTH+MAX_LOG2_RATIO
NUM_CH, 2, number of parallel channels, packed channel 0 in the LSBs
CNT_WIDTH, 16, width of the overflow counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  one sample per channel present this cycle
in_data  in  NUM_CH*DATA_WIDTH  packed two's-complement samples
cfg_log2_ratio  in  $clog2(MAX_LOG2_RATIO+1)  decimation exponent R (ratio 2^R)
cfg_mode  in  2  0=sum, 1=average, 2=pick, 3=reserved (treated as sum)
cfg_offset_bin  in  1  1: convert each sample to offset binary (invert MSB) and accumulate unsigned; 0: signed accumulate
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_data  out  NUM_CH*(DATA_WIDTH+MAX_LOG2_RATIO)  packed per-channel results
overflow_cnt  out  CNT_WIDTH  dropped-result count, saturating
frame_active  out  1  high while a frame is partially accumulated

Behaviour:
- Reset: all of the following are cleared to 0: accumulators, sample counter, out_valid, out_data, overflow_cnt, frame_active, and the latched configuration.
- Config latching: cfg_* is latched on the in_valid cycle that starts a frame (sample count 0). Changes mid-frame take effect from the next frame.
- R clamp: an R above MAX_LOG2_RATIO is clamped to MAX_LOG2_RATIO.
- Per-sample conversion:
  - offset_bin=1: x' = {~x[MSB], x[MSB-1:0]}, zero-extended.
  - offset_bin=0: x sign-extended to DATA_WIDTH+MAX_LOG2_RATIO.
- Accumulation: on each in_valid, acc <= (count==0) ? x' : acc + x'. Cycles without in_valid hold all state.
- Counter: the sample counter increments on in_valid and wraps at 2^R-1.
- frame_active: high from the first sample of a frame until the frame completes.
- Frame completion: on the in_valid cycle with count == 2^R-1, the result is formed from acc + x' (or from x' alone if R=0).
  - sum: full-width result.
  - average: result >> R. Arithmetic shift when signed, logical when offset binary. Result is extended to full output width.
  - pick: first sample of the frame, extended.
- Result latency: the result is presented the cycle after the completing sample. out_valid rises that cycle.
- R=0: every sample is a frame; throughput is 1 result per cycle when out_ready stays high.
- Handshake:
  - out_data is held stable and out_valid stays high until out_valid && out_ready.
  - A handshake in the same cycle as a new completion: the register reloads with the new result and out_valid stays 1. No drop.
  - A completion while out_valid=1 and out_ready=0: the new result is discarded, the old result is kept, and overflow_cnt increments (saturating at all-ones).
  - Accumulation never stalls; in_valid has no ready.
- Reset mid-frame: the partial frame is discarded and the next sample starts a new frame.
- Arithmetic cannot overflow: 2^MAX_LOG2_RATIO samples fit in DATA_WIDTH+MAX_LOG2_RATIO bits for both signed and unsigned.

Decomposition:
- Shared package downsamp_pkg contains:
  - mode enum (MODE_SUM, MODE_AVG, MODE_PICK) and the out-width localparam function.
  - sample conversion function (offset-binary / sign-extend).
- One sub-module, downsamp_ch: per-channel accumulator, first-sample store and result formatter, instantiated NUM_CH times via generate.
- The top level owns the shared counter, config latch, output register, handshake and overflow counter.

Test Plan:
- Signed sum: R=2, mode=sum, offset_bin=0, ch0 samples 100,-50,7,-1 with out_ready=1 -> one out_valid pulse, ch0 result 56 sign-extended to 18 bits, the cycle after the 4th sample.
- Offset-binary average: R=4, mode=avg, offset_bin=1, 16 samples of -8192 (0x2000) -> each converts to 0. 16 samples of 8191 -> 0x3FFF.
- Pick mode: R=3, mode=pick, samples 5,9,9,9,9,9,9,9 -> result 5. Changing R to 1 mid-frame -> current frame still 8 samples, next frame 2 samples.
- Back-pressure: R=0, out_ready=0 for 5 consecutive samples -> out_data holds the first sample, overflow_cnt=4. Then out_ready=1 -> handshake, counter holds 4.
- Simultaneous handshake and completion: R=0, out_ready=1, in_valid every cycle -> out_valid continuously 1, every sample emitted, overflow_cnt stays 0.
- Reset mid-frame: R=2, 2 samples then rst pulse, then 4 samples of 1 -> single result 4, overflow_cnt=0, frame_active low after rst.
